// File: rtl/hasti_interconnect_pkg.sv
// Shared HASTI types and the default vscale address map (ROM, SRAM, I/O).
package pk_hasti;

  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} hresp_t;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;

  typedef enum logic [1:0] {OK = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2} ic_state_t;

  localparam logic [31:0] addr_rom = 32'h0000_0000;
  localparam logic [31:0] size_rom = 32'h0001_0000;
  localparam logic [31:0] addr_ram = 32'h0001_0000;
  localparam logic [31:0] size_ram = 32'h0001_0000;
  localparam logic [31:0] addr_io  = 32'h4000_0000;

endpackage

// File: rtl/hasti_interconnect_if.sv
// Single-master / N-slave HASTI bus bundle; m_* is the master link, s_* the shared slave side.
interface hasti_interconnect_if
  import pk_hasti::*;
#(
  parameter int NSLV = 3,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [AW-1:0]            m_haddr;
  logic                     m_hwrite;
  logic [2:0]               m_hsize;
  logic [2:0]               m_hburst;
  logic [3:0]               m_hprot;
  logic [1:0]               m_htrans;
  logic                     m_hmastlock;
  logic [DW-1:0]            m_hwdata;
  logic [DW-1:0]            m_hrdata;
  logic                     m_hready;
  logic                     m_hresp;

  logic [NSLV-1:0]          s_hsel;
  logic [AW-1:0]            s_haddr;
  logic                     s_hwrite;
  logic [2:0]               s_hsize;
  logic [2:0]               s_hburst;
  logic [3:0]               s_hprot;
  logic [1:0]               s_htrans;
  logic                     s_hmastlock;
  logic [DW-1:0]            s_hwdata;
  logic [NSLV-1:0][DW-1:0]  s_hrdata;
  logic [NSLV-1:0]          s_hreadyout;
  logic [NSLV-1:0]          s_hresp;

  modport master (
    output m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_htrans, m_hmastlock, m_hwdata,
    input  m_hrdata, m_hready, m_hresp
  );

  // m_hready doubles as every slave's hready input
  modport slave (
    input  s_hsel, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock,
           s_hwdata, m_hready,
    output s_hrdata, s_hreadyout, s_hresp
  );

  modport ic (
    input  m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_htrans, m_hmastlock, m_hwdata,
           s_hrdata, s_hreadyout, s_hresp,
    output m_hrdata, m_hready, m_hresp,
           s_hsel, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock,
           s_hwdata
  );
endinterface

// File: rtl/hasti_interconnect_addr_decoder.sv
// Priority address decoder: lowest matching slave index wins, hit_def when nothing matches.
module hasti_addr_decoder #(
  parameter int                       NSLV     = 3,
  parameter int                       AW       = 32,
  parameter logic [NSLV-1:0][AW-1:0]  SLV_BASE = '0,
  parameter logic [NSLV-1:0][AW-1:0]  SLV_MASK = '0
) (
  input  logic [AW-1:0]   haddr,
  output logic [NSLV-1:0] hsel,
  output logic            hit_def
);

  always_comb begin
    hsel    = '0;
    hit_def = 1'b1;
    for (int i = 0; i < NSLV; i++) begin
      if (hit_def && ((haddr & SLV_MASK[i]) == SLV_BASE[i])) begin
        hsel[i] = 1'b1;
        hit_def = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hasti_interconnect.sv
// HASTI interconnect: one master, NSLV slaves, built-in ERROR default slave and
// a per-transfer watchdog that aborts a hung slave data phase with ERROR.
module hasti_interconnect
  import pk_hasti::*;
#(
  parameter int                       NSLV     = 3,
  parameter int                       AW       = 32,
  parameter int                       DW       = 32,
  parameter logic [NSLV-1:0][AW-1:0]  SLV_BASE = {addr_io, addr_ram, addr_rom},
  parameter logic [NSLV-1:0][AW-1:0]  SLV_MASK = {32'hC000_0000, ~(size_ram - 32'd1),
                                                  ~(size_rom - 32'd1)},
  parameter int                       TIMEOUT  = 64
) (
  input logic              hclk,
  input logic              hreset,
  hasti_interconnect_if.ic bus
);

  localparam int             SW  = $clog2(NSLV + 1);
  localparam logic [SW-1:0]  DEF = SW'(NSLV);

  logic [NSLV-1:0] hsel;
  logic            hit_def;
  logic [SW-1:0]   asel, dsel;
  logic            dact;
  ic_state_t       state, state_d;
  logic            sel_ready, sel_resp;
  logic [DW-1:0]   sel_rdata;
  logic            hready, hresp;
  logic            waiting, fire, enter_err;

  hasti_addr_decoder #(
    .NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_dec (
    .haddr   (bus.m_haddr),
    .hsel    (hsel),
    .hit_def (hit_def)
  );

  assign bus.s_hsel      = hsel;
  assign bus.s_haddr     = bus.m_haddr;
  assign bus.s_hwrite    = bus.m_hwrite;
  assign bus.s_hsize     = bus.m_hsize;
  assign bus.s_hburst    = bus.m_hburst;
  assign bus.s_hprot     = bus.m_hprot;
  assign bus.s_htrans    = bus.m_htrans;
  assign bus.s_hmastlock = bus.m_hmastlock;
  assign bus.s_hwdata    = bus.m_hwdata;

  always_comb begin
    asel = DEF;
    for (int i = 0; i < NSLV; i++)
      if (hsel[i]) asel = SW'(i);
  end

  // Default slave reads as zero-wait OKAY; its active-transfer ERROR comes from the FSM
  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = OKAY;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel == SW'(i)) begin
        sel_ready = bus.s_hreadyout[i];
        sel_resp  = bus.s_hresp[i];
        sel_rdata = bus.s_hrdata[i];
      end
    end
  end

  always_comb begin
    hready = sel_ready;
    hresp  = sel_resp;
    case (state)
      ERR1:    begin hready = 1'b0; hresp = ERROR; end
      ERR2:    begin hready = 1'b1; hresp = ERROR; end
      default: ;
    endcase
  end

  assign bus.m_hready = hready;
  assign bus.m_hresp  = hresp;
  assign bus.m_hrdata = sel_rdata;

  assign waiting   = (state == OK) && (dsel != DEF) && dact && !sel_ready;
  assign enter_err = hready && hit_def && bus.m_htrans[1];

  // ERR2 accepts a new address phase, so a back-to-back unmapped access re-enters ERR1
  always_comb begin
    state_d = state;
    case (state)
      OK:      if (fire || enter_err) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = enter_err ? ERR1 : OK;
      default: state_d = OK;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= OK;
      dsel  <= DEF;
      dact  <= 1'b0;
    end else begin
      state <= state_d;
      if (hready) begin
        dsel <= asel;
        dact <= bus.m_htrans[1];
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int WCW = $clog2(TIMEOUT + 1);
      logic [WCW-1:0] wcnt;

      always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)       wcnt <= '0;
        else if (waiting) wcnt <= wcnt + 1'b1;
        else              wcnt <= '0;
      end

      assign fire = waiting && (wcnt == WCW'(TIMEOUT - 1));
    end else begin : g_nowdog
      assign fire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_hasti_interconnect.sv
// Directed bench for hasti_interconnect: slave forwarding, default-slave ERROR,
// watchdog abort, overlapping decode and asynchronous reset.
module tb_hasti_interconnect;
  import pk_hasti::*;

  localparam int NSLV = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic hclk;
  logic hreset;
  int   n_chk = 0;
  int   n_err = 0;

  hasti_interconnect_if #(.NSLV(NSLV), .AW(AW), .DW(DW)) bus ();

  // slave 1 deliberately overlaps slave 0 on 0x0000_xxxx
  hasti_interconnect #(
    .NSLV     (NSLV),
    .AW       (AW),
    .DW       (DW),
    .SLV_BASE ({32'h4000_0000, 32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hC000_0000, 32'hFFFE_0000, 32'hFFFF_0000}),
    .TIMEOUT  (4)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic master(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
    bus.m_htrans = trans;
    bus.m_haddr  = addr;
    bus.m_hwrite = wr;
  endtask

  task automatic check_rsp(input string tag, input logic rdy, input logic rsp);
    #1;
    check_val({tag, ".hready"}, 32'(bus.m_hready), 32'(rdy));
    check_val({tag, ".hresp"},  32'(bus.m_hresp),  32'(rsp));
  endtask

  initial begin
    hreset          = 1'b1;
    bus.m_haddr     = '0;
    bus.m_hwrite    = 1'b0;
    bus.m_hsize     = 3'd2;
    bus.m_hburst    = 3'd0;
    bus.m_hprot     = 4'd3;
    bus.m_htrans    = IDLE;
    bus.m_hmastlock = 1'b0;
    bus.m_hwdata    = '0;
    bus.s_hrdata[0] = 32'hAAAA_0000;
    bus.s_hrdata[1] = 32'h1111_2222;
    bus.s_hrdata[2] = 32'h4444_0002;
    bus.s_hreadyout = 3'b111;
    bus.s_hresp     = 3'b000;

    repeat (2) next_cycle();
    check_rsp("reset", 1'b1, 1'b0);
    check_val("reset.hrdata", bus.m_hrdata, 32'h0);

    // decode, including the overlap at 0x0
    master(IDLE, 32'h0000_0000, 1'b0); #1;
    check_val("dec.overlap", 32'(bus.s_hsel), 32'b001);
    master(IDLE, 32'h0001_0004, 1'b0); #1;
    check_val("dec.slv1", 32'(bus.s_hsel), 32'b010);
    master(IDLE, 32'h7FFF_FFF0, 1'b0); #1;
    check_val("dec.slv2", 32'(bus.s_hsel), 32'b100);
    master(IDLE, 32'h2000_0000, 1'b0); #1;
    check_val("dec.none", 32'(bus.s_hsel), 32'b000);
    check_val("bcast.haddr", bus.s_haddr, 32'h2000_0000);

    next_cycle();
    hreset = 1'b0;

    // read slave 1 with two wait states
    next_cycle();
    master(NONSEQ, 32'h0001_0004, 1'b0);
    check_rsp("rd1.addr", 1'b1, 1'b0);
    next_cycle();
    master(IDLE, 32'h0000_0000, 1'b0);
    bus.s_hreadyout[1] = 1'b0;
    check_rsp("rd1.wait1", 1'b0, 1'b0);
    next_cycle();
    check_rsp("rd1.wait2", 1'b0, 1'b0);
    check_val("rd1.hold_dsel", bus.m_hrdata, 32'h1111_2222);
    next_cycle();
    bus.s_hreadyout[1] = 1'b1;
    check_rsp("rd1.done", 1'b1, 1'b0);
    check_val("rd1.hrdata", bus.m_hrdata, 32'h1111_2222);

    // write to unmapped address: two-cycle ERROR
    next_cycle();
    master(NONSEQ, 32'h2000_0000, 1'b1);
    check_rsp("err.addr", 1'b1, 1'b0);
    next_cycle();
    master(IDLE, 32'h2000_0000, 1'b0);
    bus.m_hwdata = 32'hDEAD_BEEF;
    check_rsp("err.cyc1", 1'b0, 1'b1);
    check_val("bcast.hwdata", bus.s_hwdata, 32'hDEAD_BEEF);
    next_cycle();
    check_rsp("err.cyc2", 1'b1, 1'b1);
    next_cycle();
    check_rsp("idle_def1", 1'b1, 1'b0);
    check_val("idle_def.hrdata", bus.m_hrdata, 32'h0);
    next_cycle();
    check_rsp("idle_def2", 1'b1, 1'b0);

    // watchdog: slave 2 never becomes ready
    master(NONSEQ, 32'h4000_0000, 1'b0);
    next_cycle();
    master(NONSEQ, 32'h0000_8000, 1'b0);
    bus.s_hreadyout[2] = 1'b0;
    check_rsp("wd.wait1", 1'b0, 1'b0);
    next_cycle();
    check_rsp("wd.wait2", 1'b0, 1'b0);
    next_cycle();
    check_rsp("wd.wait3", 1'b0, 1'b0);
    next_cycle();
    check_rsp("wd.wait4", 1'b0, 1'b0);
    next_cycle();
    check_rsp("wd.err1", 1'b0, 1'b1);
    next_cycle();
    check_rsp("wd.err2", 1'b1, 1'b1);
    next_cycle();
    bus.s_hreadyout[2] = 1'b1;
    master(NONSEQ, 32'h2000_0000, 1'b0);
    check_rsp("wd.next", 1'b1, 1'b0);
    check_val("wd.next.hrdata", bus.m_hrdata, 32'hAAAA_0000);

    // async reset in the middle of ERR1
    next_cycle();
    master(IDLE, 32'h0000_0000, 1'b0);
    check_rsp("rst.err1", 1'b0, 1'b1);
    hreset = 1'b1;
    check_rsp("rst.async", 1'b1, 1'b0);
    next_cycle();
    hreset = 1'b0;
    next_cycle();
    check_rsp("rst.after", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
